// File: rtl/ultrasonic_ranger_if.sv
// Sensor-side and display-side signals of the ultrasonic ranger.
// The ranger uses the master modport; the sensor/display side uses slave.
interface ultrasonic_ranger_if;
  logic        echo;
  logic        trigger;
  logic [31:0] distance;
  logic        valid;
  logic        timeout;
  logic        busy;

  modport master (input echo, output trigger, distance, valid, timeout, busy);
  modport slave  (output echo, input trigger, distance, valid, timeout, busy);
endinterface

// File: rtl/ultrasonic_ranger.sv
// HC-SR04-style ranger: periodic trigger, echo width measured in whole cm, timeout flag.
// Define AVG4_EN to publish a 4-sample moving average instead of the raw result.
module ultrasonic_ranger #(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned TRIG_US     = 10,
  parameter int unsigned PERIOD_US   = 60_000,
  parameter int unsigned TIMEOUT_US  = 25_000,
  parameter int unsigned US_PER_CM   = 58,
  parameter int unsigned MAX_CM      = 999
) (
  input  logic                clock,
  input  logic                reset_n,
  ultrasonic_ranger_if.master bus
);
  localparam int unsigned CYC_US     = CLK_FREQ_HZ / 1_000_000;
  localparam logic [31:0] TRIG_LAST  = 32'(TRIG_US * CYC_US - 1);
  localparam logic [31:0] PER_LAST   = 32'(PERIOD_US * CYC_US - 1);
  localparam logic [31:0] TO_LAST    = 32'(TIMEOUT_US * CYC_US - 1);
  localparam logic [31:0] CM_LAST    = 32'(US_PER_CM * CYC_US - 1);
  localparam logic [31:0] CM_MAX     = 32'(MAX_CM);

  typedef enum logic [1:0] {IDLE, TRIG, WAIT_RISE, MEASURE} state_t;

  state_t      state, state_nxt;
  logic        echo_s1, echo_s2, echo_prev;
  logic        rise, fall;
  logic [31:0] period_cnt, timer, pre, cm, cm_nxt;
  logic        started, period_wrap, pre_wrap;
  logic        go_trig, start_meas, accept, tmo;
  logic [31:0] distance_r;
  logic        valid_r, timeout_r;

  assign rise        = echo_s2 & ~echo_prev;
  assign fall        = ~echo_s2 & echo_prev;
  assign period_wrap = (period_cnt == PER_LAST);
  assign pre_wrap    = (pre == CM_LAST);
  // The current MEASURE cycle is counted too, so a fall publishes the updated count.
  assign cm_nxt      = !pre_wrap ? cm : (cm == CM_MAX) ? cm : cm + 32'd1;

  always_comb begin
    state_nxt  = state;
    go_trig    = 1'b0;
    start_meas = 1'b0;
    accept     = 1'b0;
    tmo        = 1'b0;
    case (state)
      IDLE: if (!started || period_wrap) begin
        state_nxt = TRIG;
        go_trig   = 1'b1;
      end
      TRIG: if (timer == TRIG_LAST) state_nxt = WAIT_RISE;
      WAIT_RISE: if (rise) begin
        state_nxt  = MEASURE;
        start_meas = 1'b1;
      end else if (timer == TO_LAST) begin
        state_nxt = IDLE;
        tmo       = 1'b1;
      end
      MEASURE: if (fall) begin
        state_nxt = IDLE;
        accept    = 1'b1;
      end else if (timer == TO_LAST) begin
        state_nxt = IDLE;
        tmo       = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      echo_s1    <= 1'b0;
      echo_s2    <= 1'b0;
      echo_prev  <= 1'b0;
      period_cnt <= '0;
      timer      <= '0;
      pre        <= '0;
      cm         <= '0;
      started    <= 1'b0;
      valid_r    <= 1'b0;
      timeout_r  <= 1'b0;
    end else begin
      state     <= state_nxt;
      echo_s1   <= bus.echo;
      echo_s2   <= echo_s1;
      echo_prev <= echo_s2;
      valid_r   <= accept;
      if (go_trig) started <= 1'b1;
      period_cnt <= (go_trig || period_wrap) ? '0 : period_cnt + 32'd1;
      timer      <= (state_nxt != state || state == IDLE) ? '0 : timer + 32'd1;
      if (start_meas) begin
        pre <= '0;
        cm  <= '0;
      end else if (state == MEASURE) begin
        pre <= pre_wrap ? '0 : pre + 32'd1;
        cm  <= cm_nxt;
      end
      if (tmo)         timeout_r <= 1'b1;
      else if (accept) timeout_r <= 1'b0;
    end
  end

`ifdef AVG4_EN
  logic [31:0] hist [4];
  logic        filled;
  logic [31:0] avg_sum;

  // Oldest entry drops out; the new raw sample joins the three newest.
  assign avg_sum = cm_nxt + hist[0] + hist[1] + hist[2];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) hist[i] <= '0;
      filled     <= 1'b0;
      distance_r <= '0;
    end else if (accept) begin
      filled <= 1'b1;
      if (!filled) begin
        for (int i = 0; i < 4; i++) hist[i] <= cm_nxt;
        distance_r <= cm_nxt;
      end else begin
        hist[0]    <= cm_nxt;
        hist[1]    <= hist[0];
        hist[2]    <= hist[1];
        hist[3]    <= hist[2];
        distance_r <= avg_sum >> 2;
      end
    end
  end
`else
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)    distance_r <= '0;
    else if (accept) distance_r <= cm_nxt;
  end
`endif

  assign bus.trigger  = (state == TRIG);
  assign bus.busy     = (state != IDLE);
  assign bus.distance = distance_r;
  assign bus.valid    = valid_r;
  assign bus.timeout  = timeout_r;
endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Directed bench for ultrasonic_ranger: 1 cycle = 1 us, PERIOD 2000, TIMEOUT 1500.
// Unit a uses MAX_CM=999, unit b uses MAX_CM=20; both share clock and reset.
module tb_ultrasonic_ranger;
  logic clock;
  logic reset_n;
  logic sel;
  int   cyc, errors, checks;
  int   vld_a, vld_b;
  int   t_rise;

`ifdef AVG4_EN
  localparam int E638 = 10;
  localparam int E116 = 8;
  localparam int E22  = 13;
`else
  localparam int E638 = 11;
  localparam int E116 = 2;
  localparam int E22  = 22;
`endif

  ultrasonic_ranger_if ifa ();
  ultrasonic_ranger_if ifb ();

  ultrasonic_ranger #(.CLK_FREQ_HZ(1_000_000), .PERIOD_US(2000), .TIMEOUT_US(1500))
    u_a (.clock(clock), .reset_n(reset_n), .bus(ifa));
  ultrasonic_ranger #(.CLK_FREQ_HZ(1_000_000), .PERIOD_US(2000), .TIMEOUT_US(1500), .MAX_CM(20))
    u_b (.clock(clock), .reset_n(reset_n), .bus(ifb));

  logic        trig_m, valid_m, tmo_m, busy_m;
  logic [31:0] dist_m;
  assign trig_m  = sel ? ifb.trigger  : ifa.trigger;
  assign valid_m = sel ? ifb.valid    : ifa.valid;
  assign tmo_m   = sel ? ifb.timeout  : ifa.timeout;
  assign busy_m  = sel ? ifb.busy     : ifa.busy;
  assign dist_m  = sel ? ifb.distance : ifa.distance;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (ifa.valid) vld_a = vld_a + 1;
    if (ifb.valid) vld_b = vld_b + 1;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d required < 90000", cyc);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int vld_m();
    return sel ? vld_b : vld_a;
  endfunction

  task automatic set_echo(input logic v);
    if (sel) ifb.echo = v;
    else     ifa.echo = v;
  endtask

  // Returns at the first negedge with trigger low after a trigger pulse; w = pulse width.
  task automatic wait_trig_fall(output int w);
    int n;
    n = 0;
    while (!trig_m && n < 3000) begin
      @(negedge clock);
      n++;
    end
    t_rise = cyc;
    chk("trig_rise_seen", 32'(trig_m), 1);
    w = 0;
    while (trig_m && w < 3000) begin
      @(negedge clock);
      w++;
    end
    chk("trig_fall_seen", 32'(trig_m), 0);
  endtask

  task automatic wait_tmo(output int n);
    n = 0;
    while (!tmo_m && n < 2000) begin
      @(negedge clock);
      n++;
    end
  endtask

  task automatic do_echo(input int width, input int exp_d);
    int w, v0;
    wait_trig_fall(w);
    repeat (5) @(negedge clock);
    set_echo(1'b1);
    repeat (width) @(negedge clock);
    set_echo(1'b0);
    v0 = vld_m();
    repeat (2) @(negedge clock);
    chk("valid_early", 32'(valid_m), 0);
    @(negedge clock);
    chk("valid_at_3", 32'(valid_m), 1);
    chk("distance", dist_m, 32'(exp_d));
    chk("timeout_clear", 32'(tmo_m), 0);
    @(negedge clock);
    chk("valid_drop", 32'(valid_m), 0);
    chk("valid_once", 32'(vld_m() - v0), 1);
  endtask

  initial begin
    int w, n, t1, t_rel, v0;
    sel = 1'b0; ifa.echo = 1'b0; ifb.echo = 1'b0;
    cyc = 0; errors = 0; checks = 0; vld_a = 0; vld_b = 0;
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_trigger", 32'(ifa.trigger), 0);
    chk("rst_distance", ifa.distance, 0);
    chk("rst_valid", 32'(ifa.valid), 0);
    chk("rst_timeout", 32'(ifa.timeout), 0);
    chk("rst_busy", 32'(ifa.busy), 0);
    reset_n = 1'b1;
    t_rel = cyc;

    // First period: trigger start, width, echo-less timeout, period length.
    wait_trig_fall(w);
    chk("trig_start", 32'(t_rise - t_rel), 1);
    chk("trig_width", 32'(w), 10);
    t1 = t_rise;
    wait_tmo(n);
    chk("tmo_wait_first", 32'(n), 1500);
    chk("dist_init", ifa.distance, 0);
    wait_trig_fall(w);
    chk("period", 32'(t_rise - t1), 2000);
    chk("no_valid_yet", 32'(vld_a), 0);

    do_echo(580, 10);
    do_echo(638, E638);
    do_echo(637, 10);

    // No echo: timeout after 1500 cycles, distance held.
    wait_trig_fall(w);
    v0 = vld_a;
    wait_tmo(n);
    chk("tmo_wait", 32'(n), 1500);
    chk("tmo_dist_held", ifa.distance, 10);
    repeat (2) @(negedge clock);
    chk("tmo_no_valid", 32'(vld_a - v0), 0);
    do_echo(116, E116);

    // Saturating unit: long echo clamps, stuck echo times out.
    sel = 1'b1;
    do_echo(1400, 20);
    wait_trig_fall(w);
    repeat (5) @(negedge clock);
    set_echo(1'b1);
    v0 = vld_b;
    wait_tmo(n);
    chk("stuck_tmo_wait", 32'(n), 1503);
    chk("stuck_dist_held", ifb.distance, 20);
    chk("stuck_no_valid", 32'(vld_b - v0), 0);
    set_echo(1'b0);
    sel = 1'b0;

    // Fresh history, then a reset mid-measurement.
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst2_distance", ifa.distance, 0);
    reset_n = 1'b1;
    do_echo(580, 10);
    do_echo(580, 10);
    do_echo(580, 10);
    do_echo(1276, E22);

    wait_trig_fall(w);
    repeat (5) @(negedge clock);
    set_echo(1'b1);
    repeat (100) @(negedge clock);
    chk("mid_busy", 32'(ifa.busy), 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_trigger", 32'(ifa.trigger), 0);
    chk("mid_rst_distance", ifa.distance, 0);
    chk("mid_rst_valid", 32'(ifa.valid), 0);
    chk("mid_rst_timeout", 32'(ifa.timeout), 0);
    chk("mid_rst_busy", 32'(ifa.busy), 0);
    set_echo(1'b0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    do_echo(116, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
